// File: rtl/multi_n_to_1_arb.sv
// N:1 streaming merge with a registered output stage and per-packet channel locking.
// Arbitration is round-robin or fixed lowest-index priority, selected by PRIORITY_MODE.
module multi_n_to_1_arb #(
    parameter int WIDTH         = 8,
    parameter int N             = 4,
    parameter int PRIORITY_MODE = 0,
    localparam int SELW         = (N > 2) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    input  logic [N-1:0]         in_last,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready,
    output logic                 dbg_state
);

    // Handshake: a beat moves on a channel in any cycle where its valid and ready are both
    // high; valid never depends on ready, and at most one in_ready bit is set per cycle.

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [SELW-1:0] ptr, ptr_nxt;
    logic [SELW-1:0] lock_ch, lock_nxt;
    logic [SELW-1:0] grant_idx;
    logic            grant_valid;
    logic            load_en;
    logic            xfer;
    int              rr_idx;

    assign dbg_state = state;
    assign load_en   = !out_valid || out_ready;
    assign xfer      = grant_valid && load_en && !rst;

    // Candidates are scanned from the far end so the last hit is the winner.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        rr_idx      = 0;
        if (state == LOCKED) begin
            grant_valid = in_valid[lock_ch];
            grant_idx   = lock_ch;
        end else if (PRIORITY_MODE != 0) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SELW'(i);
                end
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                rr_idx = int'(ptr) + k;
                if (rr_idx >= N) begin
                    rr_idx = rr_idx - N;
                end
                if (in_valid[rr_idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SELW'(rr_idx);
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        lock_nxt  = lock_ch;
        if (xfer) begin
            if (in_last[grant_idx]) begin
                state_nxt = IDLE;
                ptr_nxt   = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + SELW'(1);
            end else begin
                state_nxt = LOCKED;
                lock_nxt  = grant_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            lock_ch <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            lock_ch <= lock_nxt;
        end
    end

    // A drain and a load on the same edge simply replace the beat; out_valid stays high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[grant_idx*WIDTH +: WIDTH];
            out_last  <= in_last[grant_idx];
            out_sel   <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
